// File: rtl/tug_scorer_pkg.sv
// Shared game definitions: FSM state encoding, rope-position constants and the LED decode helper.
package tug_scorer_pkg;

  localparam int unsigned POS_W = 4;
  localparam int unsigned LED_W = 9;

  localparam logic [POS_W-1:0] POS_CENTER = POS_W'(4);
  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(8);

  typedef enum logic [1:0] {
    StArmed,
    StGo,
    StScored,
    StDone
  } state_e;

  // One-hot rope LED pattern for a position; bit 0 is the left end.
  function automatic logic [LED_W-1:0] pos_to_leds(input logic [POS_W-1:0] pos);
    return LED_W'(1) << pos;
  endfunction

endpackage

// File: rtl/tug_scorer_pb_sync.sv
// Pushbutton conditioner: two-flop synchroniser followed by a registered rising-edge detector.
// A raw rise produces a one-cycle press pulse three clock edges later.
module pb_sync (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);

  logic sync1_q, sync2_q, prev_q, press_q;

  // Synchronise the raw button and register the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tug_scorer.sv
// Tug-of-war scorer: conditions both player buttons, runs the round FSM and tracks the rope
// position shown on a one-hot LED bar until one end is reached.
module tug_scorer
  import tug_scorer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pbl,
  input  logic             pbr,
  input  logic             leds_on,
  input  logic             clear,
  output logic             winrnd,
  output logic [LED_W-1:0] leds,
  output logic             game_over,
  output logic             winner
);

  logic press_l, press_r;

  pb_sync u_sync_l (
    .clk   (clk),
    .rst   (rst),
    .pb    (pbl),
    .press (press_l)
  );

  pb_sync u_sync_r (
    .clk   (clk),
    .rst   (rst),
    .pb    (pbr),
    .press (press_r)
  );

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [LED_W-1:0]   leds_q;
  logic               winrnd_q, winrnd_d;

  // Next-state, position update and round-decided pulse.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    winrnd_d = 1'b0;
    case (state_q)
      StArmed: begin
        if (clear) begin
          state_d = StArmed;
        end else if (press_l && press_r) begin
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (press_l) begin
          // Early press is a foul: the opponent scores.
          pos_d    = pos_q + POS_W'(1);
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (press_r) begin
          pos_d    = pos_q - POS_W'(1);
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (leds_on) begin
          state_d = StGo;
        end
      end
      StGo: begin
        if (clear) begin
          state_d = StArmed;
        end else if (press_l && press_r) begin
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (press_l) begin
          pos_d    = pos_q - POS_W'(1);
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (press_r) begin
          pos_d    = pos_q + POS_W'(1);
          state_d  = StScored;
          winrnd_d = 1'b1;
        end else if (!leds_on) begin
          state_d = StArmed;
        end
      end
      StScored: begin
        // Reaching an end wins the game; this takes precedence over re-arming.
        if (pos_q == '0 || pos_q == POS_MAX) begin
          state_d = StDone;
        end else if (clear) begin
          state_d = StArmed;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StArmed;
      end
    endcase
  end

  // State, position, LED and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StArmed;
      pos_q    <= POS_CENTER;
      leds_q   <= pos_to_leds(POS_CENTER);
      winrnd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      leds_q   <= pos_to_leds(pos_d);
      winrnd_q <= winrnd_d;
    end
  end

  assign winrnd    = winrnd_q;
  assign leds      = leds_q;
  assign game_over = (state_q == StDone);
  assign winner    = game_over && (pos_q == POS_MAX);

endmodule

// File: tb/tb_tug_scorer.sv
// Self-checking bench for tug_scorer: table-driven rounds with a scoreboard of expected LED
// patterns, plus hand-written sequences for game end, clear priority and reset mid-round.
module tb_tug_scorer;

  logic       clk, rst, pbl, pbr, leds_on, clear;
  logic       winrnd, game_over, winner;
  logic [8:0] leds;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb[$];

  typedef struct {
    logic       go;
    logic       l;
    logic       r;
    logic [8:0] exp_leds;
  } vec_t;

  vec_t vecs[6];

  tug_scorer dut (
    .clk       (clk),
    .rst       (rst),
    .pbl       (pbl),
    .pbr       (pbr),
    .leds_on   (leds_on),
    .clear     (clear),
    .winrnd    (winrnd),
    .leds      (leds),
    .game_over (game_over),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0; clear = 1'b0;
    tick(2);
    rst = 1'b0;
    sb.delete();
  endtask

  // Play one round; returns with the DUT in its first SCORED cycle when hold is set.
  task automatic do_round(input logic go, input logic l, input logic r,
                          input logic [8:0] exp_leds, input bit hold);
    int         n;
    bit         found;
    logic [8:0] exp;
    leds_on = go;
    tick(2);
    pbl = l;
    pbr = r;
    sb.push_back(exp_leds);
    n = 0;
    found = 0;
    while (n < 12 && !found) begin
      tick(1);
      n++;
      if (winrnd === 1'b1) found = 1;
    end
    check("round_latency", 32'(n), 32'd4);
    exp = sb.pop_front();
    check("round_leds", 32'(leds), 32'(exp));
    if (!hold) begin
      tick(1);
      check("winrnd_width", 32'(winrnd), 32'd0);
      pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0; clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(5);
    end
  endtask

  initial begin
    int wr;

    vecs[0] = '{go: 1'b1, l: 1'b0, r: 1'b1, exp_leds: 9'b000100000}; // right win 4->5
    vecs[1] = '{go: 1'b1, l: 1'b1, r: 1'b0, exp_leds: 9'b000010000}; // left win 5->4
    vecs[2] = '{go: 1'b1, l: 1'b1, r: 1'b1, exp_leds: 9'b000010000}; // tie in GO
    vecs[3] = '{go: 1'b0, l: 1'b1, r: 1'b0, exp_leds: 9'b000100000}; // left foul 4->5
    vecs[4] = '{go: 1'b0, l: 1'b0, r: 1'b1, exp_leds: 9'b000010000}; // right foul 5->4
    vecs[5] = '{go: 1'b0, l: 1'b1, r: 1'b1, exp_leds: 9'b000010000}; // tie while armed

    do_reset();
    check("reset_leds", 32'(leds), 32'h010);
    check("reset_winrnd", 32'(winrnd), 32'd0);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_round(vecs[i].go, vecs[i].l, vecs[i].r, vecs[i].exp_leds, 1'b0);
    end

    // Clear coincides with the right press pulse while in GO.
    do_reset();
    leds_on = 1'b1;
    tick(2);
    pbr = 1'b1;
    tick(3);
    clear = 1'b1;
    wr = 0;
    tick(1);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (winrnd === 1'b1) wr++;
      tick(1);
    end
    check("clear_prio_winrnd", 32'(wr), 32'd0);
    check("clear_prio_leds", 32'(leds), 32'h010);
    pbr = 1'b0; leds_on = 1'b0;
    tick(5);

    // Four left wins reach the left end.
    do_reset();
    do_round(1'b1, 1'b1, 1'b0, 9'b000001000, 1'b0);
    do_round(1'b1, 1'b1, 1'b0, 9'b000000100, 1'b0);
    do_round(1'b1, 1'b1, 1'b0, 9'b000000010, 1'b0);
    do_round(1'b1, 1'b1, 1'b0, 9'b000000001, 1'b0);
    check("left_end_game_over", 32'(game_over), 32'd1);
    check("left_end_winner", 32'(winner), 32'd0);
    leds_on = 1'b1; pbr = 1'b1; clear = 1'b1;
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (winrnd === 1'b1) wr++;
    end
    clear = 1'b0; pbr = 1'b0; pbl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (winrnd === 1'b1) wr++;
    end
    check("done_no_winrnd", 32'(wr), 32'd0);
    check("done_leds_frozen", 32'(leds), 32'h001);
    check("done_game_over_held", 32'(game_over), 32'd1);
    check("done_winner_held", 32'(winner), 32'd0);

    // Four right wins reach the right end.
    do_reset();
    check("rst_from_done_game_over", 32'(game_over), 32'd0);
    do_round(1'b1, 1'b0, 1'b1, 9'b000100000, 1'b0);
    do_round(1'b1, 1'b0, 1'b1, 9'b001000000, 1'b0);
    do_round(1'b1, 1'b0, 1'b1, 9'b010000000, 1'b0);
    do_round(1'b1, 1'b0, 1'b1, 9'b100000000, 1'b0);
    check("right_end_game_over", 32'(game_over), 32'd1);
    check("right_end_winner", 32'(winner), 32'd1);
    check("right_end_leds", 32'(leds), 32'h100);

    // Reset in the SCORED cycle that brought the rope to position 7.
    do_reset();
    do_round(1'b1, 1'b0, 1'b1, 9'b000100000, 1'b0);
    do_round(1'b1, 1'b0, 1'b1, 9'b001000000, 1'b0);
    do_round(1'b1, 1'b0, 1'b1, 9'b010000000, 1'b1);
    rst = 1'b1;
    tick(1);
    check("mid_scored_rst_leds", 32'(leds), 32'h010);
    check("mid_scored_rst_game_over", 32'(game_over), 32'd0);
    check("mid_scored_rst_winrnd", 32'(winrnd), 32'd0);
    rst = 1'b0; pbr = 1'b0; leds_on = 1'b0;
    tick(5);
    check("post_rst_leds", 32'(leds), 32'h010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tug_scorer.md
TUG_SCORER -- requirements
Module: tug_scorer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port pbl, input, 1, left player pushbutton; raw and asynchronous.
REQ-004 SHALL have port pbr, input, 1, right player pushbutton; raw and asynchronous.
REQ-005 SHALL have port leds_on, input, 1, round "go" indication from master control; level.
REQ-006 SHALL have port clear, input, 1, round re-arm request from master control; level, sampled each cycle.
REQ-007 SHALL have port winrnd, output, 1, one-cycle pulse when a round is decided (win, foul or tie).
REQ-008 SHALL have port leds, output, 9, one-hot rope position, bit 0 = left end, bit 8 = right end.
REQ-009 SHALL have port game_over, output, 1, high once either end is reached; held until rst.
REQ-010 SHALL have port winner, output, 1, 0 = left, 1 = right; valid only while game_over = 1.

Function
REQ-011 SHALL pass pbl and pbr each through a 2-flop synchroniser plus a rising-edge detector; a press = one-cycle edge pulse, 3 cycles after the raw rise.
REQ-012 SHALL hold position pos as 4-bit unsigned, range 0..8, centre 4; leds = 1 << pos, registered.
REQ-013 SHALL implement states ARMED, GO, SCORED, DONE.
REQ-014 ARMED: leds_on = 1 with no press in the same cycle -> GO; a single press -> foul, opponent scores, go to SCORED; both presses in the same cycle -> tie, no move, go to SCORED.
REQ-015 GO: the first single press scores for the presser -> SCORED; both presses in the same cycle -> tie -> SCORED; leds_on deasserting with no press -> ARMED.
REQ-016 A left score SHALL decrement pos; a right score SHALL increment pos; the update is applied on the same edge as the transition to SCORED.
REQ-017 winrnd SHALL be asserted exactly one cycle, the first cycle in SCORED, for every decided round including ties and fouls.
REQ-018 SCORED: presses ignored; clear = 1 -> ARMED; if the new pos is 0 or 8 -> DONE instead, regardless of clear.
REQ-019 DONE: game_over = 1; winner = (pos == 8); pos is frozen; presses, leds_on and clear are ignored; exit only via rst.
REQ-020 clear = 1 in ARMED or GO SHALL force ARMED with no score and no winrnd; clear has priority over a same-cycle press.
REQ-021 pos SHALL never wrap: a decrement at 0 or an increment at 8 is unreachable because DONE is entered first.
REQ-022 Round latency: press edge detected -> winrnd high on the next cycle.

Reset
REQ-023 rst = 1 SHALL, on the next clk edge, force: state ARMED, pos 4, leds 9'b000010000, winrnd 0, game_over 0, winner 0, synchroniser and edge-detector flops 0.
REQ-024 rst SHALL override all other inputs in every state, including DONE and mid-SCORED, with no partial pos update.

Structure
REQ-025 State encoding and constants POS_CENTER = 4, POS_MAX = 8 and POS_W = 4 SHALL reside in the shared game package.
REQ-026 The synchroniser plus edge detector SHALL be one sub-module, pb_sync, instantiated once per button.

Verification
REQ-027 Reset, then leds_on = 1, then pbr pulse -> winrnd one pulse 4 cycles after the raw rise; leds = 9'b000100000.
REQ-028 pbl pressed while leds_on = 0 (foul) -> right scores; pos 4 -> 5; winrnd pulses once.
REQ-029 pbl and pbr rising in the same cycle during GO -> tie; pos unchanged at 4; winrnd pulses once.
REQ-030 Four consecutive left wins, each separated by clear -> pos 0; leds = 9'b000000001; game_over = 1; winner = 0; further presses and clear cause no change.
REQ-031 clear and a pbr edge in the same GO cycle -> state ARMED; no winrnd; pos unchanged.
REQ-032 rst asserted in the SCORED cycle after pos reached 7 -> pos 4, game_over 0, winrnd 0 on the next edge.
